// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and command-word helper for the LCD
// window writer.
package lcd_pkg;

    // Controller command opcodes
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Index of the final command word (11 words: 0..10)
    localparam logic [3:0] CMD_LAST_IDX = 4'd10;

    // RGB565 colour constants
    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_PIX_HI = 3'd3,
        ST_PIX_LO = 3'd4,
        ST_DONE   = 3'd5
    } lcd_state_t;

    // Window-setup word for a given index; bit8 = 1 marks a data byte
    function automatic logic [8:0] cmd_word(input logic [3:0]  idx,
                                            input logic [15:0] x0,
                                            input logic [15:0] x1,
                                            input logic [15:0] y0,
                                            input logic [15:0] y1);
        logic [8:0] word;
        case (idx)
            4'd0:    word = {1'b0, CMD_CASET};
            4'd1:    word = {1'b1, x0[15:8]};
            4'd2:    word = {1'b1, x0[7:0]};
            4'd3:    word = {1'b1, x1[15:8]};
            4'd4:    word = {1'b1, x1[7:0]};
            4'd5:    word = {1'b0, CMD_RASET};
            4'd6:    word = {1'b1, y0[15:8]};
            4'd7:    word = {1'b1, y0[7:0]};
            4'd8:    word = {1'b1, y1[15:8]};
            4'd9:    word = {1'b1, y1[7:0]};
            4'd10:   word = {1'b0, CMD_RAMWR};
            default: word = 9'h000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/lcd_win_addr_gen.sv
// Row/column walker over the clipped window and pixel-memory address
// generator (row-major, address = (y0+row)*LCD_W + x0+col).
module lcd_win_addr_gen
    import lcd_pkg::*;
#(
    parameter int LCD_W  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [15:0]       i_x0,
    input  logic [15:0]       i_y0,
    input  logic [15:0]       i_eff_w,
    input  logic [15:0]       i_eff_h,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_rom_addr
);

    localparam logic [39:0] LCD_W_40 = 40'(LCD_W);

    logic [15:0] r_row;
    logic [15:0] r_col;
    logic [39:0] w_addr_full;

    // Advance the column, wrapping into the next row at the window edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (r_col == i_eff_w - 16'd1) begin
                r_col <= '0;
                r_row <= r_row + 16'd1;
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end

    // Full-width address first, then resize to the memory address width
    always_comb begin
        w_addr_full = (40'(i_y0) + 40'(r_row)) * LCD_W_40
                    + 40'(i_x0) + 40'(r_col);
        o_rom_addr  = w_addr_full[ADDR_W-1:0];
        o_last      = (r_row == i_eff_h - 16'd1) && (r_col == i_eff_w - 16'd1);
    end

endmodule

// File: rtl/lcd_show_window.sv
// Draws a clipped rectangular window on an LCD: emits the column/row
// address setup and memory-write commands, then every pixel as two bytes,
// either a solid colour or words read from a pixel memory.
module lcd_show_window
    import lcd_pkg::*;
#(
    parameter int LCD_W   = 240,
    parameter int LCD_H   = 320,
    parameter int ADDR_W  = 17,
    parameter int ROM_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [15:0]       x0,
    input  logic [15:0]       y0,
    input  logic [15:0]       w,
    input  logic [15:0]       h,
    input  logic [15:0]       fill_color,
    input  logic              wr_done,
    input  logic [15:0]       rom_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [8:0]        show_data,
    output logic              en_write,
    output logic              busy,
    output logic              show_done
);

    localparam logic [16:0] LCD_W_17 = 17'(LCD_W);
    localparam logic [16:0] LCD_H_17 = 17'(LCD_H);
    localparam logic [2:0]  LAT_LAST = 3'(ROM_LAT);

    lcd_state_t  r_state;
    logic        r_mode;
    logic [15:0] r_x0;
    logic [15:0] r_y0;
    logic [15:0] r_eff_w;
    logic [15:0] r_eff_h;
    logic [15:0] r_pix;
    logic [3:0]  r_idx;
    logic [2:0]  r_lat;
    logic        r_pending;
    logic [8:0]  r_show_data;
    logic        r_en_write;
    logic        r_busy;
    logic        r_show_done;

    logic [16:0] w_room_x;
    logic [16:0] w_room_y;
    logic [15:0] w_eff_w;
    logic [15:0] w_eff_h;
    logic        w_empty;
    logic        w_accept;
    logic        w_ack;
    logic        w_last;
    logic        w_step;
    logic [15:0] w_x1;
    logic [15:0] w_y1;

    // Clip the requested window against the panel and detect empty windows
    always_comb begin
        w_room_x = LCD_W_17 - {1'b0, x0};
        w_room_y = LCD_H_17 - {1'b0, y0};
        w_eff_w  = ({1'b0, w} < w_room_x) ? w : w_room_x[15:0];
        w_eff_h  = ({1'b0, h} < w_room_y) ? h : w_room_y[15:0];
        w_empty  = ({1'b0, x0} >= LCD_W_17) || ({1'b0, y0} >= LCD_H_17)
                || (w == 16'd0) || (h == 16'd0);
        w_accept = start && !r_busy;
        // wr_done only counts when a word is actually outstanding
        w_ack    = r_pending && wr_done;
        w_step   = (r_state == ST_PIX_LO) && w_ack && !w_last;
        w_x1     = r_x0 + r_eff_w - 16'd1;
        w_y1     = r_y0 + r_eff_h - 16'd1;
    end

    lcd_win_addr_gen #(
        .LCD_W  (LCD_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_rst_n),
        .i_clear    (w_accept),
        .i_step     (w_step),
        .i_x0       (r_x0),
        .i_y0       (r_y0),
        .i_eff_w    (r_eff_w),
        .i_eff_h    (r_eff_h),
        .o_last     (w_last),
        .o_rom_addr (rom_addr)
    );

    // Main sequencer: command words, pixel fetch and byte-pair output
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_eff_w     <= '0;
            r_eff_h     <= '0;
            r_pix       <= '0;
            r_idx       <= '0;
            r_lat       <= '0;
            r_pending   <= 1'b0;
            r_show_data <= '0;
            r_en_write  <= 1'b0;
            r_busy      <= 1'b0;
            r_show_done <= 1'b0;
        end else begin
            r_en_write  <= 1'b0;
            r_show_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        r_mode    <= mode;
                        r_x0      <= x0;
                        r_y0      <= y0;
                        r_eff_w   <= w_eff_w;
                        r_eff_h   <= w_eff_h;
                        r_pix     <= fill_color;
                        r_idx     <= '0;
                        r_lat     <= '0;
                        r_pending <= 1'b0;
                        // Empty windows finish through DONE without raising busy
                        if (w_empty) begin
                            r_state     <= ST_DONE;
                            r_show_done <= 1'b1;
                        end else begin
                            r_state <= ST_CMD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_CMD: begin
                    if (!r_pending) begin
                        r_show_data <= cmd_word(r_idx, r_x0, w_x1, r_y0, w_y1);
                        r_en_write  <= 1'b1;
                        r_pending   <= 1'b1;
                    end else if (w_ack) begin
                        r_pending <= 1'b0;
                        if (r_idx == CMD_LAST_IDX) begin
                            r_lat   <= '0;
                            r_state <= r_mode ? ST_FETCH : ST_PIX_HI;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (r_lat == LAT_LAST) begin
                        r_pix   <= rom_q;
                        r_state <= ST_PIX_HI;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                ST_PIX_HI: begin
                    if (!r_pending) begin
                        r_show_data <= {1'b1, r_pix[15:8]};
                        r_en_write  <= 1'b1;
                        r_pending   <= 1'b1;
                    end else if (w_ack) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_PIX_LO;
                    end
                end
                ST_PIX_LO: begin
                    if (!r_pending) begin
                        r_show_data <= {1'b1, r_pix[7:0]};
                        r_en_write  <= 1'b1;
                        r_pending   <= 1'b1;
                    end else if (w_ack) begin
                        r_pending <= 1'b0;
                        if (w_last) begin
                            r_state     <= ST_DONE;
                            r_show_done <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_lat   <= '0;
                            r_state <= r_mode ? ST_FETCH : ST_PIX_HI;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign show_data = r_show_data;
    assign en_write  = r_en_write;
    assign busy      = r_busy;
    assign show_done = r_show_done;

endmodule

// File: tb/tb_lcd_show_window.sv
// Directed and randomized checks of lcd_show_window against a word-list
// model of the window protocol.
module tb_lcd_show_window;

    localparam int LCD_W   = 240;
    localparam int LCD_H   = 320;
    localparam int ADDR_W  = 17;
    localparam int ROM_LAT = 2;
    localparam int BUDGET  = 4000;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              start;
    logic              mode;
    logic [15:0]       x0, y0, w, h, fill_color;
    logic              wr_done;
    logic [15:0]       rom_q;
    logic [ADDR_W-1:0] rom_addr;
    logic [8:0]        show_data;
    logic              en_write;
    logic              busy;
    logic              show_done;

    int errors = 0;
    int checks = 0;
    int ack_dly = 3;      // 0 selects a random 1..4 cycle acknowledge delay
    int spur_word = 0;    // after acking this word number, hold wr_done one extra cycle

    logic [8:0]        got_w[$];
    logic [ADDR_W-1:0] got_a[$];
    logic [8:0]        exp_w[$];
    logic [ADDR_W-1:0] exp_a[$];

    logic [15:0] rom_pipe [ROM_LAT];

    lcd_show_window #(
        .LCD_W   (LCD_W),
        .LCD_H   (LCD_H),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .mode       (mode),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .fill_color (fill_color),
        .wr_done    (wr_done),
        .rom_q      (rom_q),
        .rom_addr   (rom_addr),
        .show_data  (show_data),
        .en_write   (en_write),
        .busy       (busy),
        .show_done  (show_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] rom_model(input int unsigned a);
        int unsigned v;
        v = a * 32'd2654435761;
        return v[26:11];
    endfunction

    // Pixel memory: content is a hash of the address, ROM_LAT register stages
    always @(posedge sys_clk) begin
        rom_pipe[0] <= rom_model(int'(rom_addr));
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Write engine: record each word, acknowledge it after a delay
    initial begin
        logic [8:0] word;
        int d;
        wr_done = 1'b0;
        @(posedge sys_clk); #1;
        forever begin
            if (en_write === 1'b1 && sys_rst_n === 1'b1) begin
                word = show_data;
                got_w.push_back(show_data);
                got_a.push_back(rom_addr);
                d = (ack_dly == 0) ? int'($urandom_range(1, 4)) : ack_dly;
                repeat (d) @(posedge sys_clk);
                #1;
                wr_done = 1'b1;
                if (sys_rst_n) chk("data_stable", 32'(show_data), 32'(word));
                @(posedge sys_clk); #1;
                if (got_w.size() == spur_word) begin
                    @(posedge sys_clk); #1;
                end
                wr_done = 1'b0;
            end else begin
                @(posedge sys_clk); #1;
            end
        end
    end

    // Expected word list and pixel addresses from the window rules
    task automatic build_model(input logic m, input int ax0, input int ay0,
                               input int aw, input int ah, input logic [15:0] col);
        int ew, eh, x1, y1;
        int unsigned a;
        logic [15:0] pix;
        exp_w.delete();
        exp_a.delete();
        if (ax0 >= LCD_W || ay0 >= LCD_H) return;
        ew = (aw < LCD_W - ax0) ? aw : LCD_W - ax0;
        eh = (ah < LCD_H - ay0) ? ah : LCD_H - ay0;
        if (ew == 0 || eh == 0) return;
        x1 = ax0 + ew - 1;
        y1 = ay0 + eh - 1;
        exp_w.push_back(9'h02A);
        exp_w.push_back({1'b1, 8'((ax0 >> 8) & 255)});
        exp_w.push_back({1'b1, 8'(ax0 & 255)});
        exp_w.push_back({1'b1, 8'((x1 >> 8) & 255)});
        exp_w.push_back({1'b1, 8'(x1 & 255)});
        exp_w.push_back(9'h02B);
        exp_w.push_back({1'b1, 8'((ay0 >> 8) & 255)});
        exp_w.push_back({1'b1, 8'(ay0 & 255)});
        exp_w.push_back({1'b1, 8'((y1 >> 8) & 255)});
        exp_w.push_back({1'b1, 8'(y1 & 255)});
        exp_w.push_back(9'h02C);
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                a = int'(unsigned'((ay0 + r) * LCD_W + ax0 + c)) % (32'd1 << ADDR_W);
                pix = m ? rom_model(a) : col;
                exp_a.push_back(ADDR_W'(a));
                exp_w.push_back({1'b1, pix[15:8]});
                exp_w.push_back({1'b1, pix[7:0]});
            end
        end
    endtask

    task automatic run_op(input string tag, input logic m, input int ax0, input int ay0,
                          input int aw, input int ah, input logic [15:0] col,
                          input bit extra_start);
        int cyc, n_done, n_busy, n;
        build_model(m, ax0, ay0, aw, ah, col);
        got_w.delete();
        got_a.delete();
        @(posedge sys_clk); #1;
        mode = m; x0 = 16'(ax0); y0 = 16'(ay0); w = 16'(aw); h = 16'(ah);
        fill_color = col; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        // Scramble inputs: the running operation must not see these
        mode = ~m; x0 = 16'($urandom_range(0, 200)); y0 = 16'($urandom_range(0, 300));
        w = 16'($urandom_range(1, 9)); h = 16'($urandom_range(1, 9)); fill_color = 16'($urandom);
        if (exp_w.size() == 0) begin
            chk({tag, "_done_next"}, 32'(show_done), 32'd1);
            chk({tag, "_busy_low"}, 32'(busy), 32'd0);
            n_done = 0; n_busy = 0;
            repeat (6) begin
                @(posedge sys_clk); #1;
                n_done += int'(show_done);
                n_busy += int'(busy);
            end
            chk({tag, "_extra_done"}, 32'(n_done), 32'd0);
            chk({tag, "_busy_seen"}, 32'(n_busy), 32'd0);
            chk({tag, "_words"}, 32'(got_w.size()), 32'd0);
        end else begin
            chk({tag, "_busy_start"}, 32'(busy), 32'd1);
            cyc = 0;
            while (show_done !== 1'b1 && cyc < BUDGET) begin
                start = (extra_start && cyc == 3) ? 1'b1 : 1'b0;
                @(posedge sys_clk); #1;
                cyc++;
            end
            start = 1'b0;
            chk({tag, "_done_seen"}, 32'(show_done), 32'd1);
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            n_done = 0;
            repeat (6) begin
                @(posedge sys_clk); #1;
                n_done += int'(show_done);
            end
            chk({tag, "_extra_done"}, 32'(n_done), 32'd0);
            chk({tag, "_words"}, 32'(got_w.size()), 32'(exp_w.size()));
            n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
            for (int i = 0; i < n; i++)
                chk($sformatf("%s_word%0d", tag, i), 32'(got_w[i]), 32'(exp_w[i]));
            for (int k = 0; k < exp_a.size(); k++)
                if (11 + 2 * k < got_a.size())
                    chk($sformatf("%s_addr%0d", tag, k), 32'(got_a[11 + 2 * k]), 32'(exp_a[k]));
        end
    endtask

    initial begin
        int cyc;
        sys_rst_n = 1'b0;
        start = 1'b0; mode = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; fill_color = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_show_data", 32'(show_data), 32'h000);
        chk("rst_en_write", 32'(en_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_show_done", 32'(show_done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        ack_dly = 3;
        run_op("fill_2x2", 1'b0, 10, 20, 2, 2, 16'hF800, 1'b0);
        run_op("img_3x1", 1'b1, 0, 0, 3, 1, 16'h0000, 1'b0);
        run_op("clip_x", 1'b0, 238, 0, 10, 1, 16'h07E0, 1'b0);
        run_op("x0_240", 1'b0, 240, 0, 4, 4, 16'h001F, 1'b0);
        run_op("y0_320", 1'b1, 0, 320, 4, 4, 16'h0000, 1'b0);
        run_op("w_zero", 1'b0, 5, 5, 0, 3, 16'hFFFF, 1'b0);
        run_op("clip_y", 1'b1, 100, 318, 2, 5, 16'h0000, 1'b0);

        spur_word = 11;
        run_op("restart_spur", 1'b1, 4, 7, 2, 2, 16'h0000, 1'b1);
        spur_word = 0;

        ack_dly = 0;
        for (int t = 0; t < 14; t++) begin
            int rx, ry;
            rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(LCD_W - 4, LCD_W)) : int'($urandom_range(0, LCD_W - 1));
            ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(LCD_H - 4, LCD_H)) : int'($urandom_range(0, LCD_H - 1));
            run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), rx, ry,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 16'($urandom), 1'b0);
        end

        // Reset in the middle of the first pixel, then a fresh 1x1 fill
        ack_dly = 3;
        got_w.delete();
        got_a.delete();
        @(posedge sys_clk); #1;
        mode = 1'b0; x0 = 16'd30; y0 = 16'd40; w = 16'd3; h = 16'd3;
        fill_color = 16'h1234; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (got_w.size() < 12 && cyc < BUDGET) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        chk("midrst_reached_pixel", 32'(got_w.size()), 32'd12);
        sys_rst_n = 1'b0;
        #2;
        chk("midrst_show_data", 32'(show_data), 32'h000);
        chk("midrst_en_write", 32'(en_write), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_show_done", 32'(show_done), 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (6) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        cyc = 0;
        repeat (8) begin
            @(posedge sys_clk); #1;
            cyc += int'(show_done) + int'(en_write);
        end
        chk("midrst_no_activity", 32'(cyc), 32'd0);
        run_op("after_rst", 1'b0, 5, 6, 1, 1, 16'hABCD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
